// File: rtl/arb_pkg.sv
// Shared definitions for the bus arbiter port and the central controller:
// controller command codes, communication-state codes and the port state enum.
package arb_pkg;

   // Commands issued by the central controller to a port
   typedef enum logic [1:0] {
      CMD_WAIT   = 2'b00,
      CMD_STOP_S = 2'b01,
      CMD_STOP_P = 2'b10,
      CMD_CLEAR  = 2'b11
   } cmd_e;

   // Communication state reported by a port to the controller
   typedef enum logic [1:0] {
      CS_END_COM  = 2'b00,
      CS_NAK      = 2'b01,
      CS_WAIT_ACK = 2'b10,
      CS_COM      = 2'b11
   } com_state_e;

   // Port state machine
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACK_WAIT,
      ST_COM,
      ST_STOP,
      ST_DONE,
      ST_NAK
   } port_state_e;

   // True for either flavour of stop command
   function automatic logic is_stop_cmd(input logic [1:0] c);
      return (c == CMD_STOP_S) || (c == CMD_STOP_P);
   endfunction

endpackage

// File: rtl/m_ack_timer.sv
// Acknowledge timeout counter for the arbiter port.
// Compiled only when ARB_PORT_TIMEOUT_EN is defined; without the macro the
// port has no timeout and this module does not exist.
`ifdef ARB_PORT_TIMEOUT_EN
module m_ack_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rstN,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q;

   // Count enabled cycles, saturating at the last value; clear has priority
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && (count_q != LAST)) begin
         count_q <= count_q + 1'b1;
      end
   end

   // Expired during the TIMEOUT-th enabled cycle after a clear
   assign expired = enable && (count_q == LAST);

endmodule
`endif

// File: rtl/m_arbiter_port.sv
// Bus arbiter port: takes a core request for a slave, negotiates with the
// central controller (CLEAR / STOP_S / STOP_P), waits for the slave to become
// ready and grants or holds the core. All outputs are registered.
// Optional macro ARB_PORT_TIMEOUT_EN: enables the acknowledge timeout that
// refuses the request (nak) when the slave never becomes ready.
module m_arbiter_port
   import arb_pkg::*;
#(
   parameter int NO_SLAVES   = 3,
   parameter int S_ID_WIDTH  = $clog2(NO_SLAVES + 1),
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  req,
   input  logic [S_ID_WIDTH-1:0] req_slave,
   input  logic                  xfer_done,
   input  logic                  core_stopped,
   input  logic                  slave_ready,
   input  logic [1:0]            cmd,
   output logic [S_ID_WIDTH-1:0] id,
   output logic [1:0]            com_state,
   output logic                  done,
   output logic                  grant,
   output logic                  hold,
   output logic                  save,
   output logic                  nak_o
);

   localparam logic [S_ID_WIDTH-1:0] MAX_ID = S_ID_WIDTH'(NO_SLAVES);

   port_state_e           state_q;
   logic [S_ID_WIDTH-1:0] id_q;
   logic [1:0]            com_state_q;
   logic                  done_q;
   logic                  grant_q;
   logic                  hold_q;
   logic                  save_q;
   logic                  req_valid;

   // A request names a real slave: non-zero and within range
   assign req_valid = req && (req_slave != '0) && (req_slave <= MAX_ID);

`ifdef ARB_PORT_TIMEOUT_EN
   logic nak_q;
   logic expired;

   m_ack_timer #(
      .TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .clk     (clk),
      .rstN    (rstN),
      .clear   (state_q != ST_ACK_WAIT),
      .enable  (state_q == ST_ACK_WAIT),
      .expired (expired)
   );
`else
   // Timeout length has no meaning without the timer
   logic unused_ack_timeout;
   assign unused_ack_timeout = (ACK_TIMEOUT == 0);
`endif

   // Port state machine with registered outputs updated alongside the state
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= ST_IDLE;
         id_q        <= '0;
         com_state_q <= CS_END_COM;
         done_q      <= 1'b0;
         grant_q     <= 1'b0;
         hold_q      <= 1'b0;
         save_q      <= 1'b0;
`ifdef ARB_PORT_TIMEOUT_EN
         nak_q       <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef ARB_PORT_TIMEOUT_EN
         nak_q  <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  state_q <= ST_REQ;
                  id_q    <= req_slave;
               end
            end
            ST_REQ: begin
               if (cmd == CMD_CLEAR) begin
                  state_q     <= ST_ACK_WAIT;
                  com_state_q <= CS_WAIT_ACK;
               end
            end
            ST_ACK_WAIT: begin
               // Ready beats a simultaneous timeout
               if (slave_ready) begin
                  state_q     <= ST_COM;
                  com_state_q <= CS_COM;
                  grant_q     <= 1'b1;
               end
`ifdef ARB_PORT_TIMEOUT_EN
               else if (expired) begin
                  state_q     <= ST_NAK;
                  com_state_q <= CS_NAK;
                  nak_q       <= 1'b1;
               end
`endif
            end
            ST_COM: begin
               // Completion beats a simultaneous stop request
               if (xfer_done) begin
                  state_q     <= ST_IDLE;
                  com_state_q <= CS_END_COM;
                  id_q        <= '0;
                  grant_q     <= 1'b0;
               end else if (is_stop_cmd(cmd)) begin
                  state_q <= ST_STOP;
                  grant_q <= 1'b0;
                  hold_q  <= 1'b1;
                  save_q  <= (cmd == CMD_STOP_S);
               end
            end
            ST_STOP: begin
               if (core_stopped) begin
                  state_q     <= ST_DONE;
                  com_state_q <= CS_END_COM;
                  done_q      <= 1'b1;
                  hold_q      <= 1'b0;
                  save_q      <= 1'b0;
               end
            end
            ST_DONE: begin
               // Re-arbitrate for the same slave
               state_q <= ST_REQ;
            end
`ifdef ARB_PORT_TIMEOUT_EN
            ST_NAK: begin
               state_q     <= ST_IDLE;
               com_state_q <= CS_END_COM;
               id_q        <= '0;
            end
`endif
            default: begin
               state_q     <= ST_IDLE;
               com_state_q <= CS_END_COM;
               id_q        <= '0;
               grant_q     <= 1'b0;
               hold_q      <= 1'b0;
               save_q      <= 1'b0;
            end
         endcase
      end
   end

   assign id        = id_q;
   assign com_state = com_state_q;
   assign done      = done_q;
   assign grant     = grant_q;
   assign hold      = hold_q;
   assign save      = save_q;
`ifdef ARB_PORT_TIMEOUT_EN
   assign nak_o     = nak_q;
`else
   assign nak_o     = 1'b0;
`endif

endmodule

// File: tb/tb_m_arbiter_port.sv
// Self-checking bench for m_arbiter_port: directed scenarios followed by a
// random run, all compared each cycle against a behavioural model.
module tb_m_arbiter_port;

   localparam int NS = 3;
   localparam int SW = 2;
   localparam int TO = 16;
`ifdef ARB_PORT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstN;
   logic          req;
   logic [SW-1:0] req_slave;
   logic          xfer_done;
   logic          core_stopped;
   logic          slave_ready;
   logic [1:0]    cmd;
   logic [SW-1:0] id;
   logic [1:0]    com_state;
   logic          done;
   logic          grant;
   logic          hold;
   logic          save;
   logic          nak_o;

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model: phase name plus the values each output should show
   string m_phase;
   int    m_id, m_cs, m_done, m_grant, m_hold, m_save, m_nak, m_wait;

   m_arbiter_port #(
      .NO_SLAVES   (NS),
      .ACK_TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .rstN         (rstN),
      .req          (req),
      .req_slave    (req_slave),
      .xfer_done    (xfer_done),
      .core_stopped (core_stopped),
      .slave_ready  (slave_ready),
      .cmd          (cmd),
      .id           (id),
      .com_state    (com_state),
      .done         (done),
      .grant        (grant),
      .hold         (hold),
      .save         (save),
      .nak_o        (nak_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".id"},    8'(id),        8'(m_id));
      check({tag, ".cs"},    8'(com_state), 8'(m_cs));
      check({tag, ".done"},  8'(done),      8'(m_done));
      check({tag, ".grant"}, 8'(grant),     8'(m_grant));
      check({tag, ".hold"},  8'(hold),      8'(m_hold));
      check({tag, ".save"},  8'(save),      8'(m_save));
      check({tag, ".nak"},   8'(nak_o),     8'(m_nak));
   endtask

   task automatic model_reset();
      m_phase = "IDLE";
      m_id = 0; m_cs = 0; m_done = 0; m_grant = 0;
      m_hold = 0; m_save = 0; m_nak = 0; m_wait = 0;
   endtask

   // Apply the port's rules to the inputs present at this clock edge
   task automatic model_step();
      m_done = 0;
      m_nak  = 0;
      if (m_phase == "IDLE") begin
         if (req && int'(req_slave) >= 1 && int'(req_slave) <= NS) begin
            m_phase = "REQ";
            m_id    = int'(req_slave);
         end
      end else if (m_phase == "REQ") begin
         if (cmd == 2'b11) begin
            m_phase = "ACKW";
            m_cs    = 2;
            m_wait  = 1;
         end
      end else if (m_phase == "ACKW") begin
         if (slave_ready) begin
            m_phase = "COM"; m_cs = 3; m_grant = 1;
         end else if (TO_EN && m_wait == TO) begin
            m_phase = "NAK"; m_cs = 1; m_nak = 1;
         end else begin
            m_wait++;
         end
      end else if (m_phase == "NAK") begin
         m_phase = "IDLE"; m_cs = 0; m_id = 0;
      end else if (m_phase == "COM") begin
         if (xfer_done) begin
            m_phase = "IDLE"; m_cs = 0; m_id = 0; m_grant = 0;
         end else if (cmd == 2'b01 || cmd == 2'b10) begin
            m_phase = "STOP"; m_grant = 0; m_hold = 1;
            m_save  = (cmd == 2'b01) ? 1 : 0;
         end
      end else if (m_phase == "STOP") begin
         if (core_stopped) begin
            m_phase = "DONE"; m_done = 1; m_hold = 0; m_save = 0; m_cs = 0;
         end
      end else if (m_phase == "DONE") begin
         m_phase = "REQ";
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic go_com(input logic [SW-1:0] s);
      req = 1'b1; req_slave = s;
      tick("gc_req");
      req = 1'b0; cmd = 2'b11;
      tick("gc_clr");
      cmd = 2'b00; slave_ready = 1'b1;
      tick("gc_rdy");
      slave_ready = 1'b0;
   endtask

   initial begin
      rstN = 1'b0; req = 1'b0; req_slave = '0; xfer_done = 1'b0;
      core_stopped = 1'b0; slave_ready = 1'b0; cmd = 2'b00;
      model_reset();
      #1;
      check_all("reset");
      #2 rstN = 1'b1;

      // Basic request / clear / ready / transfer
      req = 1'b1; req_slave = 2'd2;
      tick("b_req");
      check("b_req_id", 8'(id), 8'd2);
      req = 1'b0;
      for (int i = 0; i < 3; i++) tick("b_reqw");
      cmd = 2'b11;
      tick("b_clr");
      check("b_wait_ack", 8'(com_state), 8'd2);
      cmd = 2'b00;
      tick("b_aw1");
      tick("b_aw2");
      slave_ready = 1'b1;
      tick("b_com");
      check("b_com_cs", 8'(com_state), 8'd3);
      check("b_grant", 8'(grant), 8'd1);
      slave_ready = 1'b0;
      tick("b_com2");
      xfer_done = 1'b1;
      tick("b_xfer");
      check("b_end_id", 8'(id), 8'd0);
      check("b_end_cs", 8'(com_state), 8'd0);
      xfer_done = 1'b0;
      tick("b_idle");

      // Stop with save, then re-arbitration
      go_com(2'd1);
      cmd = 2'b01;
      tick("s_stop");
      check("s_hold", 8'(hold), 8'd1);
      check("s_save", 8'(save), 8'd1);
      check("s_grant", 8'(grant), 8'd0);
      check("s_cs", 8'(com_state), 8'd3);
      cmd = 2'b10;
      for (int i = 0; i < 3; i++) tick("s_hold_w");
      cmd = 2'b00; core_stopped = 1'b1;
      tick("s_done");
      check("s_done_pulse", 8'(done), 8'd1);
      core_stopped = 1'b0;
      tick("s_req");
      check("s_done_gone", 8'(done), 8'd0);
      check("s_id_kept", 8'(id), 8'd1);
      cmd = 2'b11;
      tick("s_clr");
      cmd = 2'b00; slave_ready = 1'b1;
      tick("s_com");
      check("s_regrant", 8'(grant), 8'd1);
      slave_ready = 1'b0; xfer_done = 1'b1;
      tick("s_xfer");
      xfer_done = 1'b0;

      // Stop-abort colliding with transfer completion
      go_com(2'd3);
      cmd = 2'b10; xfer_done = 1'b1;
      tick("p_coll");
      check("p_hold", 8'(hold), 8'd0);
      check("p_id", 8'(id), 8'd0);
      cmd = 2'b00; xfer_done = 1'b0;
      for (int i = 0; i < 3; i++) tick("p_after");

      // Slave never ready: timeout if enabled, otherwise indefinite wait
      req = 1'b1; req_slave = 2'd3;
      tick("t_req");
      req = 1'b0; cmd = 2'b11;
      tick("t_clr");
      cmd = 2'b00;
      for (int i = 0; i < 15; i++) tick("t_wait");
      check("t_still_wait", 8'(com_state), 8'd2);
      tick("t_edge");
`ifdef ARB_PORT_TIMEOUT_EN
      check("t_nak_cs", 8'(com_state), 8'd1);
      check("t_nak_pulse", 8'(nak_o), 8'd1);
`else
      check("t_no_nak_cs", 8'(com_state), 8'd2);
      check("t_no_nak", 8'(nak_o), 8'd0);
`endif
      tick("t_after");
      slave_ready = 1'b1;
      tick("t_rdy");
      slave_ready = 1'b0; xfer_done = 1'b1;
      tick("t_xfer");
      xfer_done = 1'b0;
      tick("t_idle");

      // Asynchronous reset in the middle of a transfer
      go_com(2'd2);
      tick("r_com");
      #2 rstN = 1'b0;
      model_reset();
      #1;
      check_all("r_async");
      check("r_grant", 8'(grant), 8'd0);
      #3 rstN = 1'b1;
      req = 1'b1; req_slave = 2'd0;
      for (int i = 0; i < 3; i++) tick("r_zero_req");
      check("r_zero_id", 8'(id), 8'd0);
      req = 1'b0;

      // Random traffic with periods where the slave never answers
      for (int i = 0; i < 3000; i++) begin
         req          = 1'($urandom_range(0, 1));
         req_slave    = SW'($urandom_range(0, 3));
         cmd          = 2'($urandom_range(0, 3));
         slave_ready  = ((i % 200) >= 60) && ($urandom_range(0, 3) == 0);
         xfer_done    = ($urandom_range(0, 7) == 0);
         core_stopped = ($urandom_range(0, 3) == 0);
         tick("rnd");
         if ((i % 500) == 499) begin
            #2 rstN = 1'b0;
            model_reset();
            #1;
            check_all("rnd_rst");
            #3 rstN = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
